// File: rtl/top_k_pkg.sv
// top_k_pkg: shared compare and saturating-increment helpers for the top-K tracker
package top_k_pkg;
  function automatic logic [63:0] sx(input logic [63:0] x, input int w, input logic sgn);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return (sgn && x[w-1]) ? (x | ~m) : (x & m);
  endfunction
  function automatic logic gt(input logic [63:0] a, input logic [63:0] b, input int w, input logic sgn);
    return sgn ? ($signed(sx(a, w, sgn)) > $signed(sx(b, w, sgn))) : (sx(a, w, sgn) > sx(b, w, sgn));
  endfunction
  function automatic logic [63:0] sat_inc(input logic [63:0] c, input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return (c == m) ? c : c + 64'd1;
  endfunction
endpackage

// File: rtl/top_k_slot.sv
// top_k_slot: one list entry; keeps its value, takes the new sample, or takes the upper neighbour
//   clear/accept: flush and sample-accept strobes; head: slot has no upper neighbour
//   sample: incoming value; up_val/up_vld: upper neighbour entry; val/vld: this entry
module top_k_slot import top_k_pkg::*; #(
  parameter int N = 10,
  parameter bit SIGNED = 1'b0
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         accept,
  input  logic         head,
  input  logic [N-1:0] sample,
  input  logic [N-1:0] up_val,
  input  logic         up_vld,
  output logic [N-1:0] val,
  output logic         vld
);
  logic [N-1:0] val_q, val_d;
  logic vld_q, vld_d, ins, up_ins;
  // ins: the sample ranks above this entry; up_ins: it also ranks above the upper one, so shift down
  always_comb begin
    ins = !vld_q || gt(64'(sample), 64'(val_q), N, SIGNED);
    up_ins = !head && (!up_vld || gt(64'(sample), 64'(up_val), N, SIGNED));
    val_d = clear ? '0 : (accept && ins) ? (up_ins ? up_val : sample) : val_q;
    vld_d = clear ? 1'b0 : (accept && ins) ? (up_ins ? up_vld : 1'b1) : vld_q;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      val_q <= '0;
      vld_q <= 1'b0;
    end else begin
      val_q <= val_d;
      vld_q <= vld_d;
    end
  end
  assign val = val_q;
  assign vld = vld_q;
endmodule

// File: rtl/top_k_tracker.sv
// top_k_tracker: streaming tracker of the K largest samples, sample count and new-maximum pulse
//   clock/reset_n: clock and async active-low reset; clear: sync flush
//   data_valid/data: sample input; top/top_valid: sorted list, index 0 largest
//   maximum: top[0]; count: saturating accepted count; new_max: one-cycle new-maximum pulse
module top_k_tracker import top_k_pkg::*; #(
  parameter int N = 10,
  parameter int K = 4,
  parameter int SIGNED = 0,
  parameter int COUNT_W = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               data_valid,
  input  logic [N-1:0]       data,
  output logic [K*N-1:0]     top,
  output logic [K-1:0]       top_valid,
  output logic [N-1:0]       maximum,
  output logic [COUNT_W-1:0] count,
  output logic               new_max
);
  logic accept;
  logic [N-1:0] val_w [K+1];
  logic [K:0] vld_w;
  logic [COUNT_W-1:0] count_q, count_d;
  logic new_max_q, new_max_d;
  assign accept = data_valid && !clear;
  // index 0 is a padding entry so slot i always sees its upper neighbour at index i
  assign val_w[0] = '0;
  assign vld_w[0] = 1'b0;
  for (genvar i = 0; i < K; i++) begin : g_slot
    top_k_slot #(.N(N), .SIGNED(SIGNED != 0)) u_slot (
      .clock(clock), .reset_n(reset_n), .clear(clear), .accept(accept), .head(i == 0),
      .sample(data), .up_val(val_w[i]), .up_vld(vld_w[i]), .val(val_w[i+1]), .vld(vld_w[i+1])
    );
    assign top[i*N +: N] = val_w[i+1];
  end
  assign top_valid = vld_w[K:1];
  assign maximum = val_w[1];
  always_comb begin
    count_d = clear ? '0 : accept ? COUNT_W'(sat_inc(64'(count_q), COUNT_W)) : count_q;
    new_max_d = accept && (!vld_w[1] || gt(64'(data), 64'(val_w[1]), N, SIGNED != 0));
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      new_max_q <= 1'b0;
    end else begin
      count_q <= count_d;
      new_max_q <= new_max_d;
    end
  end
  assign count = count_q;
  assign new_max = new_max_q;
endmodule
